// File: rtl/pwm3_phase_gen.sv
// Three-phase edge-aligned 11-bit PWM with shadowed duties, mode decode,
// period strobe and overcurrent blanking window on every output edge.
module pwm3_phase_gen #(
   parameter int BLANK_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] duty_a,
   input  logic [10:0] duty_b,
   input  logic [10:0] duty_c,
   input  logic [1:0]  mode,
   output logic        high_a,
   output logic        high_b,
   output logic        high_c,
   output logic        low_a,
   output logic        low_b,
   output logic        low_c,
   output logic        pwm_synch,
   output logic        ovr_i_blank_n
);

   localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYCLES);
   localparam logic [10:0] CNT_LAST   = 11'h7FF;

   logic [10:0] cnt;
   logic [10:0] duty_a_q, duty_b_q, duty_c_q;
   logic [2:0]  pwm;
   logic [2:0]  high_next, low_next;
   logic [2:0]  high_q, low_q;
   logic [7:0]  blank_cnt, blank_next;
   logic        edge_any;

   assign pwm = {cnt < duty_c_q, cnt < duty_b_q, cnt < duty_a_q};

   // high and low come from one mode value, so they can never both be set.
   always_comb begin
      high_next = 3'b000;
      low_next  = 3'b000;
      case (mode)
         2'b01: begin
            high_next = pwm;
            low_next  = ~pwm;
         end
         2'b10: begin
            high_next = 3'b000;
            low_next  = 3'b111;
         end
         default: begin
            high_next = 3'b000;
            low_next  = 3'b000;
         end
      endcase
      edge_any   = (high_next != high_q) || (low_next != low_q);
      blank_next = edge_any ? BLANK_LOAD :
                   ((blank_cnt != 8'd0) ? (blank_cnt - 8'd1) : 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         duty_a_q      <= '0;
         duty_b_q      <= '0;
         duty_c_q      <= '0;
         high_q        <= '0;
         low_q         <= '0;
         pwm_synch     <= 1'b0;
         blank_cnt     <= '0;
         ovr_i_blank_n <= 1'b1;
      end else begin
         cnt <= cnt + 11'd1;
         if (cnt == CNT_LAST) begin
            duty_a_q <= duty_a;
            duty_b_q <= duty_b;
            duty_c_q <= duty_c;
         end
         high_q    <= high_next;
         low_q     <= low_next;
         pwm_synch <= (cnt == 11'd0);
         blank_cnt <= blank_next;
         // Registered from the next count so blanking drops with the edge itself.
         ovr_i_blank_n <= (blank_next == 8'd0);
      end
   end

   assign high_a = high_q[0];
   assign high_b = high_q[1];
   assign high_c = high_q[2];
   assign low_a  = low_q[0];
   assign low_b  = low_q[1];
   assign low_c  = low_q[2];

endmodule
